// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg: shared FSM state type and minimum output-buffer depth for ram_stream_reader
package ram_reader_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam int MIN_FIFO_DEPTH = 3;
endpackage

// File: rtl/ram_reader_fifo.sv
// ram_reader_fifo: synchronous circular buffer with occupancy count; dout reads 0 when empty
module ram_reader_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign count = cnt_q;
  assign dout = (cnt_q != '0) ? mem_q[rd_q] : '0;
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst RAM reader feeding a valid/ready stream through a small FIFO.
// Define RAM_READER_STRIDE_EN to add the stride port; otherwise addresses step by 1.
module ram_stream_reader
  import ram_reader_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ADDRWIDTH = 8,
  parameter int FIFO_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] base_addr,
  input  logic [ADDRWIDTH:0]   count,
`ifdef RAM_READER_STRIDE_EN
  input  logic [ADDRWIDTH-1:0] stride,
`endif
  output logic                 enb,
  output logic [ADDRWIDTH-1:0] addrb,
  input  logic [WIDTH-1:0]     dob,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 busy,
  output logic                 done
);
  localparam int DEPTH = (FIFO_DEPTH < MIN_FIFO_DEPTH) ? MIN_FIFO_DEPTH : FIFO_DEPTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDRWIDTH:0] ONE = 1;
  state_t state_q, state_d;
  logic enb_q, enb_d, pend_q, done_q, done_d, pop, can_issue;
  logic [ADDRWIDTH-1:0] addr_q, addr_d, nxt_q, nxt_d, inc;
  logic [ADDRWIDTH:0] rem_q, rem_d, out_q, out_d;
  logic [CW-1:0] fcnt;
`ifdef RAM_READER_STRIDE_EN
  assign inc = stride;
`else
  assign inc = ADDRWIDTH'(1);
`endif
  assign pop = m_valid & m_ready;
  // Reserve a FIFO slot for every read still in flight so the buffer can never overflow.
  assign can_issue = int'(fcnt) + int'(pend_q) + int'(enb_q) - int'(pop) < DEPTH;
  always_comb begin
    state_d = state_q;
    enb_d = 1'b0;
    addr_d = addr_q;
    nxt_d = nxt_q;
    rem_d = rem_q;
    out_d = pop ? out_q - ONE : out_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      done_d = (count == '0);
      if (count != '0) begin
        enb_d = 1'b1;
        addr_d = base_addr;
        nxt_d = base_addr + inc;
        rem_d = count - ONE;
        out_d = count;
        state_d = (count == ONE) ? DRAIN : READ;
      end
    end else if (state_q == READ && can_issue) begin
      enb_d = 1'b1;
      addr_d = nxt_q;
      nxt_d = nxt_q + inc;
      rem_d = rem_q - ONE;
      state_d = (rem_q == ONE) ? DRAIN : READ;
    end else if (state_q == DRAIN && pop && out_q == ONE) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      enb_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      nxt_q <= '0;
      rem_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      enb_q <= enb_d;
      pend_q <= enb_q;
      done_q <= done_d;
      addr_q <= addr_d;
      nxt_q <= nxt_d;
      rem_q <= rem_d;
      out_q <= out_d;
    end
  end
  ram_reader_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(pend_q),
    .din(dob),
    .pop(pop),
    .dout(m_data),
    .count(fcnt)
  );
  assign m_valid = (fcnt != '0);
  assign enb = enb_q;
  assign addrb = addr_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed bursts checked every cycle against a queue-based burst model
module tb_ram_stream_reader;
  localparam int DEPTH = 3;
  logic clk = 0, rst = 1, start = 0, m_ready = 1;
  logic [7:0] base_addr = 0;
  logic [8:0] count = 0;
`ifdef RAM_READER_STRIDE_EN
  logic [7:0] stride = 1;
`endif
  logic enb, m_valid, busy, done;
  logic [7:0] addrb;
  logic [3:0] dob, m_data;
  logic [3:0] ram [256];
  int errors = 0, checks = 0, cyc = 0;

  ram_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
`ifdef RAM_READER_STRIDE_EN
    .stride(stride),
`endif
    .enb(enb), .addrb(addrb), .dob(dob), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (enb) dob <= ram[addrb];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Burst model: expected address and data sequences computed at start acceptance
  logic [7:0] addr_q[$];
  logic [3:0] data_q[$];
  int e_cyc[$], e_addr[$], b_cyc[$], b_data[$];
  int start_cyc = 0, done_cyc = -1, issued = 0, popped = 0;
  bit busy_m = 0, done_m = 0, rst_pend = 0, stall_prev = 0, nd, nb;
  logic [3:0] prev_data;
  logic [7:0] prev_addr = 0, inc_m, a;

  always @(negedge clk) begin
    cyc++;
    if (rst_pend) begin
      chk("rst_enb", enb, 0); chk("rst_addrb", addrb, 0); chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    end
    rst_pend = rst;
    if (rst) begin
      addr_q.delete(); data_q.delete();
      busy_m = 0; done_m = 0; issued = 0; popped = 0; stall_prev = 0; prev_addr = 0;
    end else begin
      nd = 0; nb = busy_m;
      chk("done", done, done_m);
      chk("busy", busy, busy_m);
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      if (enb) begin
        issued++;
        e_cyc.push_back(cyc - start_cyc); e_addr.push_back(addrb);
        if (addr_q.size() == 0) chk("extra_enb", enb, 0);
        else chk("addrb", addrb, addr_q.pop_front());
      end else chk("addr_hold", addrb, prev_addr);
      chk("outstanding", (issued - popped) <= DEPTH, 1);
      if (m_valid && m_ready) begin
        popped++;
        b_cyc.push_back(cyc - start_cyc); b_data.push_back(m_data);
        if (data_q.size() == 0) chk("extra_beat", m_valid, 0);
        else begin
          chk("m_data", m_data, data_q.pop_front());
          if (data_q.size() == 0) begin nd = 1; nb = 0; end
        end
      end
      if (done) done_cyc = cyc - start_cyc;
      if (start && !busy_m) begin
        start_cyc = cyc;
`ifdef RAM_READER_STRIDE_EN
        inc_m = stride;
`else
        inc_m = 1;
`endif
        if (count == 0) nd = 1;
        else begin
          nb = 1;
          for (int i = 0; i < int'(count); i++) begin
            a = 8'(int'(base_addr) + i * int'(inc_m));
            addr_q.push_back(a); data_q.push_back(ram[a]);
          end
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_data = m_data;
      prev_addr = addrb;
      done_m = nd; busy_m = nb;
    end
  end

  task automatic clear_logs();
    e_cyc.delete(); e_addr.delete(); b_cyc.delete(); b_data.delete(); done_cyc = -1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic burst(input logic [7:0] b, input logic [8:0] n, input bit toggle, input bit chain, input bit intrude);
    int k;
    clear_logs();
    base_addr = b; count = n; start = 1; m_ready = 1;
    step();
    start = 0; k = 1;
    while (done !== 1'b1 && k < 400) begin
      if (toggle) m_ready = (k % 4 == 0) || (k % 4 == 3);
      if (intrude) begin start = (k == 2); base_addr = 8'h55; count = 3; end
      step(); k++;
    end
    start = 0; m_ready = 1;
    if (done !== 1'b1) chk("burst_timeout", done, 1);
    if (!chain) begin @(negedge clk); step(); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int dup;
    logic [255:0] seen;
    for (int i = 0; i < 256; i++) ram[i] = 4'(i);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    step();
    // count=4 from 0x10 with the ready stream always ready
    burst(8'h10, 4, 0, 0, 0);
    chk("t1_enb_n", e_cyc.size(), 4);
    chk("t1_beat_n", b_cyc.size(), 4);
    if (e_cyc.size() == 4 && b_cyc.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t1_enb_cyc", e_cyc[i], i + 1); chk("t1_addr", e_addr[i], 8'h10 + i);
        chk("t1_beat_cyc", b_cyc[i], i + 3); chk("t1_data", b_data[i], i);
      end
    chk("t1_done_cyc", done_cyc, 7);
    // address wrap-around
    burst(8'hFE, 4, 0, 0, 0);
    chk("t2_n", e_addr.size(), 4);
    if (e_addr.size() == 4) begin
      chk("t2_a0", e_addr[0], 8'hFE); chk("t2_a1", e_addr[1], 8'hFF);
      chk("t2_a2", e_addr[2], 8'h00); chk("t2_a3", e_addr[3], 8'h01);
    end
    if (b_data.size() == 4) begin
      chk("t2_d0", b_data[0], 4'hE); chk("t2_d2", b_data[2], 4'h0);
    end
    // backpressure with ready pattern 1,0,0,1
    burst(8'h00, 8, 1, 0, 0);
    chk("t3_beat_n", b_data.size(), 8);
    if (b_data.size() == 8) for (int i = 0; i < 8; i++) chk("t3_data", b_data[i], i);
    // count=0 issues nothing and pulses done next cycle
    burst(8'h33, 0, 0, 0, 0);
    chk("t4_enb_n", e_cyc.size(), 0);
    chk("t4_done_cyc", done_cyc, 1);
    // start while busy is ignored
    burst(8'h60, 5, 0, 0, 1);
    chk("t5_enb_n", e_addr.size(), 5);
    // back-to-back: new start in the done cycle
    burst(8'h20, 2, 0, 1, 0);
    burst(8'h35, 1, 0, 0, 0);
    chk("t6_n", e_addr.size(), 1);
    if (e_addr.size() == 1) chk("t6_addr", e_addr[0], 8'h35);
    if (b_data.size() == 1) chk("t6_data", b_data[0], 4'h5);
    chk("t6_done_cyc", done_cyc, 4);
    // reset two cycles into a count=6 burst, then a clean burst
    clear_logs();
    base_addr = 8'h47; count = 6; start = 1;
    step(); start = 0;
    step(); rst = 1;
    step(); rst = 0;
    burst(8'h00, 2, 0, 0, 0);
    chk("t7_beat_n", b_data.size(), 2);
    if (b_data.size() == 2) begin
      chk("t7_d0", b_data[0], 0); chk("t7_d1", b_data[1], 1);
    end
    // full address space, wrapping past the top
    burst(8'h80, 256, 0, 0, 0);
    chk("t8_n", e_addr.size(), 256);
    seen = '0; dup = 0;
    foreach (e_addr[i]) begin
      if (seen[e_addr[i][7:0]]) dup++;
      seen[e_addr[i][7:0]] = 1'b1;
    end
    chk("t8_dup", dup, 0);
    chk("t8_cover", $countones(seen), 256);
    chk("t8_beat_n", b_data.size(), 256);
`ifdef RAM_READER_STRIDE_EN
    stride = 3;
    burst(8'h00, 3, 0, 0, 0);
    chk("t9_n", e_addr.size(), 3);
    if (e_addr.size() == 3) begin
      chk("t9_a0", e_addr[0], 0); chk("t9_a1", e_addr[1], 3); chk("t9_a2", e_addr[2], 6);
    end
    stride = 1;
`endif
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits.
REQ-002 SHALL have parameter ADDRWIDTH, default 8, RAM read-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 3, output buffer entries (minimum 3).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, begin a burst (sampled only in IDLE).
REQ-007 SHALL have port base_addr, input, ADDRWIDTH, first read address (sampled with start).
REQ-008 SHALL have port count, input, ADDRWIDTH+1, number of words to read, 0..2^ADDRWIDTH (sampled with start).
REQ-009 SHALL have port stride, input, ADDRWIDTH, address increment (present only under RAM_READER_STRIDE_EN).
REQ-010 SHALL have port enb, output, 1, RAM read enable.
REQ-011 SHALL have port addrb, output, ADDRWIDTH, RAM read address.
REQ-012 SHALL have port dob, input, WIDTH, RAM read data, valid one cycle after enb.
REQ-013 SHALL have port m_valid, output, 1, output stream data valid.
REQ-014 SHALL have port m_ready, input, 1, downstream ready.
REQ-015 SHALL have port m_data, output, WIDTH, output stream data.
REQ-016 SHALL have port busy, output, 1, burst in progress.
REQ-017 SHALL have port done, output, 1, one-cycle burst-complete pulse.

Function
REQ-018 SHALL implement FSM IDLE -> READ (start, count>0) -> DRAIN (last read issued) -> IDLE (last beat handshaken).
REQ-019 SHALL, on start with count=0, stay IDLE, issue no reads, pulse done in the next cycle.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL assert enb with addrb=base_addr in the cycle after start is sampled; word k read at base_addr+k*inc, modulo 2^ADDRWIDTH (wrap-around, no error).
REQ-022 SHALL issue a read only when buffered words + in-flight reads < FIFO_DEPTH; enb=0 otherwise; addrb holds its value when enb=0.
REQ-023 SHALL capture dob into the FIFO exactly one cycle after each enb; m_valid rises the cycle after capture (two cycles after enb).
REQ-024 SHALL sustain one word per cycle while m_ready=1; a beat transfers when m_valid and m_ready are both 1.
REQ-025 SHALL hold m_data stable while m_valid=1 and m_ready=0; words delivered in issue order, none lost or duplicated.
REQ-026 SHALL deassert busy and pulse done in the cycle after the last beat handshake; a new start is accepted in that same cycle.
REQ-027 SHALL, for count=2^ADDRWIDTH, read every address exactly once, wrapping past the top.

Reset
REQ-028 SHALL, on rst=1, go to IDLE and drive enb=0, addrb=0, m_valid=0, m_data=0, busy=0, done=0 from the next edge.
REQ-029 SHALL, on rst mid-burst, flush the FIFO and discard any in-flight read data; the next start begins a clean burst.

Configuration
REQ-030 SHALL, with RAM_READER_STRIDE_EN defined, expose stride and use inc=stride (stride=0 rereads one address count times).
REQ-031 SHALL, without RAM_READER_STRIDE_EN, omit the stride port and use inc=1.

Structure
REQ-032 SHALL place the FSM state enum and the minimum FIFO depth constant in package ram_reader_pkg.
REQ-033 SHALL implement the output buffer as sub-module ram_reader_fifo (synchronous, FIFO_DEPTH entries, count output).

Verification
REQ-034 SHALL cover: RAM[i]=i, start base=0x10 count=4, m_ready=1 -> enb cycles 1-4 at 0x10..0x13, m_data 0x0..0x3 in cycles 3-6, done in cycle 7.
REQ-035 SHALL cover: base=0xFE count=4 -> addrb 0xFE, 0xFF, 0x00, 0x01; data in that order.
REQ-036 SHALL cover: count=8, m_ready toggling 1,0,0,1 -> never more than 3 buffered words, all 8 words delivered in order, m_data stable while stalled.
REQ-037 SHALL cover: start with count=0 -> no enb, done one cycle later, busy stays 0.
REQ-038 SHALL cover: rst asserted 2 cycles into count=6 burst -> m_valid=0 next cycle, no stale words after a following start base=0 count=2.
REQ-039 SHALL cover, with RAM_READER_STRIDE_EN: base=0 stride=3 count=3 -> addrb 0, 3, 6.
